lcd_display_sequencer: RTL and testbench

- Parametrised successor to the fixed 16x2 LCD configure FSM.
- Runs the HD44780-style init sequence, then repeatedly refreshes an NUM_LINES x CHARS_PER_LINE character buffer to the panel.
- The host writes the buffer through a simple write port.
- Issues one 10-bit command word at a time to the downstream LCD timing/transmit block over a valid/done handshake.

---
 rtl/lcd_display_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_lcd_display_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_display_sequencer.sv
// lcd_display_sequencer: runs the HD44780-style init sequence, then keeps
// refreshing a NUM_LINES x CHARS_PER_LINE character buffer to the panel,
// one 10-bit {RS,RW,D7..D0} command at a time over a valid/done handshake.
// Optional build macro LCD_SEQ_DIRTY_REFRESH_EN: refresh passes after the
// first one only run when the buffer was written since the previous pass.
module lcd_display_sequencer #(
  parameter int unsigned NUM_LINES         = 2,
  parameter int unsigned CHARS_PER_LINE    = 16,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000,
  parameter int unsigned REFRESH_CYCLES    = 65000000,
  parameter logic [7:0]  LINE_OFFSET       = 8'h40,
  localparam int unsigned BUF_DEPTH        = NUM_LINES * CHARS_PER_LINE,
  localparam int unsigned BA_W             = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            cmd_done,
  input  logic            buf_we,
  input  logic [BA_W-1:0] buf_addr,
  input  logic [7:0]      buf_wdata,
  output logic            cmd_valid,
  output logic [9:0]      cmd_db,
  output logic            init_done,
  output logic            busy
);

  localparam int unsigned LINE_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int unsigned COL_W    = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
  localparam int unsigned MAX_WAIT = (CLEAR_WAIT_CYCLES > REFRESH_CYCLES) ?
                                     CLEAR_WAIT_CYCLES : REFRESH_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [LINE_W-1:0] LAST_LINE    = LINE_W'(NUM_LINES - 1);
  localparam logic [COL_W-1:0]  LAST_COL     = COL_W'(CHARS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  CLEAR_LAST   = CNT_W'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

  localparam logic [9:0] CMD_FUNC_SET   = 10'h038;
  localparam logic [9:0] CMD_ENTRY_MODE = 10'h006;
  localparam logic [9:0] CMD_DISP_ON    = 10'h00C;
  localparam logic [9:0] CMD_CLEAR      = 10'h001;

  typedef enum logic [3:0] {
    IDLE,
    FUNC_SET,
    ENTRY_MODE,
    DISP_ON,
    CLEAR,
    WAIT_CLEAR,
    SET_ADDR,
    WRITE_CHAR,
    WAIT_REFRESH
  } state_t;

  state_t            state, state_nxt;
  logic [LINE_W-1:0] line, line_nxt;
  logic [COL_W-1:0]  col, col_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              cmd_valid_nxt;
  logic [9:0]        cmd_db_nxt;
  logic              init_done_nxt;
  logic              busy_nxt;
  logic              done_ok;
  logic              start_pass;
  logic              load_addr;
  logic              load_char;
  logic [BA_W-1:0]   rd_idx;
  logic              wr_ok;
  logic [7:0]        buf_mem [BUF_DEPTH];

  // DDRAM start address of a display line (odd lines live at LINE_OFFSET)
  function automatic logic [6:0] line_base(input logic [LINE_W-1:0] l);
    logic [31:0] base;
    base = (l[0] ? 32'(LINE_OFFSET) : 32'd0) + 32'(l >> 1) * CHARS_PER_LINE;
    return base[6:0];
  endfunction

  // A cmd_done arriving alongside its own cmd_valid is not a completion
  assign done_ok = cmd_done && !cmd_valid;
  assign wr_ok   = buf_we && (32'(buf_addr) < BUF_DEPTH);

  // Host write port into the character buffer; out-of-range indices dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= 8'h20;
    end else if (wr_ok) begin
      buf_mem[buf_addr] <= buf_wdata;
    end
  end

`ifdef LCD_SEQ_DIRTY_REFRESH_EN
  logic dirty;

  // Tracks buffer writes since the last pass started; a write wins over clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty <= 1'b0;
    end else if (wr_ok) begin
      dirty <= 1'b1;
    end else if (start_pass) begin
      dirty <= 1'b0;
    end
  end
`endif

  // State, position counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      line      <= '0;
      col       <= '0;
      wait_cnt  <= '0;
      cmd_valid <= 1'b0;
      cmd_db    <= '0;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      line      <= line_nxt;
      col       <= col_nxt;
      wait_cnt  <= wait_cnt_nxt;
      cmd_valid <= cmd_valid_nxt;
      cmd_db    <= cmd_db_nxt;
      init_done <= init_done_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state, next command word and counter updates
  always_comb begin
    state_nxt     = state;
    line_nxt      = line;
    col_nxt       = col;
    wait_cnt_nxt  = '0;
    cmd_valid_nxt = 1'b0;
    cmd_db_nxt    = cmd_db;
    init_done_nxt = init_done;
    start_pass    = 1'b0;
    load_addr     = 1'b0;
    load_char     = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt     = FUNC_SET;
          cmd_valid_nxt = 1'b1;
          cmd_db_nxt    = CMD_FUNC_SET;
        end
      end
      FUNC_SET: begin
        if (done_ok) begin
          state_nxt     = ENTRY_MODE;
          cmd_valid_nxt = 1'b1;
          cmd_db_nxt    = CMD_ENTRY_MODE;
        end
      end
      ENTRY_MODE: begin
        if (done_ok) begin
          state_nxt     = DISP_ON;
          cmd_valid_nxt = 1'b1;
          cmd_db_nxt    = CMD_DISP_ON;
        end
      end
      DISP_ON: begin
        if (done_ok) begin
          state_nxt     = CLEAR;
          cmd_valid_nxt = 1'b1;
          cmd_db_nxt    = CMD_CLEAR;
        end
      end
      CLEAR: begin
        if (done_ok) state_nxt = WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        if (wait_cnt == CLEAR_LAST) begin
          start_pass    = 1'b1;
          init_done_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      SET_ADDR: begin
        if (done_ok) begin
          state_nxt = WRITE_CHAR;
          col_nxt   = '0;
          load_char = 1'b1;
        end
      end
      WRITE_CHAR: begin
        if (done_ok) begin
          if (col < LAST_COL) begin
            col_nxt   = col + COL_W'(1);
            load_char = 1'b1;
          end else if (line < LAST_LINE) begin
            col_nxt   = '0;
            line_nxt  = line + LINE_W'(1);
            state_nxt = SET_ADDR;
            load_addr = 1'b1;
          end else begin
            state_nxt = WAIT_REFRESH;
          end
        end
      end
      WAIT_REFRESH: begin
        if (wait_cnt == REFRESH_LAST) begin
`ifdef LCD_SEQ_DIRTY_REFRESH_EN
          // Clean buffer: counter falls back to 0 and the wait restarts
          start_pass = dirty;
`else
          start_pass = 1'b1;
`endif
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start_pass) begin
      state_nxt = SET_ADDR;
      line_nxt  = '0;
      col_nxt   = '0;
      load_addr = 1'b1;
    end

    if (load_addr) begin
      cmd_valid_nxt = 1'b1;
      cmd_db_nxt    = {3'b001, line_base(line_nxt)};
    end

    rd_idx = BA_W'(32'(line_nxt) * CHARS_PER_LINE + 32'(col_nxt));
    if (load_char) begin
      cmd_valid_nxt = 1'b1;
      cmd_db_nxt    = {2'b10, buf_mem[rd_idx]};
    end

    busy_nxt = (state_nxt != IDLE) && (state_nxt != WAIT_CLEAR) &&
               (state_nxt != WAIT_REFRESH);
  end

endmodule

// File: tb/tb_lcd_display_sequencer.sv
// Bench for lcd_display_sequencer: a 2x16 and a 20x4 instance, a transmitter
// model answering each command, and a queue of expected command words.
module tb_lcd_display_sequencer;

  localparam int unsigned CLR_W = 10;
  localparam int unsigned REF_W = 10;

  logic clk = 1'b0;
  logic reset;

  logic       a_enable, a_cmd_done, a_buf_we;
  logic [4:0] a_buf_addr;
  logic [7:0] a_buf_wdata;
  logic       a_cmd_valid;
  logic [9:0] a_cmd_db;
  logic       a_init_done, a_busy;

  logic       b_enable, b_cmd_done, b_buf_we;
  logic [6:0] b_buf_addr;
  logic [7:0] b_buf_wdata;
  logic       b_cmd_valid;
  logic [9:0] b_cmd_db;
  logic       b_init_done, b_busy;

  int checks = 0;
  int errors = 0;
  int last_wait;
  int chars_seen;
  logic [9:0] exp_q[$];
  logic [7:0] model_a [32];
  logic [7:0] model_b [80];

  lcd_display_sequencer #(
    .NUM_LINES(2), .CHARS_PER_LINE(16),
    .CLEAR_WAIT_CYCLES(CLR_W), .REFRESH_CYCLES(REF_W), .LINE_OFFSET(8'h40)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(a_enable), .cmd_done(a_cmd_done),
    .buf_we(a_buf_we), .buf_addr(a_buf_addr), .buf_wdata(a_buf_wdata),
    .cmd_valid(a_cmd_valid), .cmd_db(a_cmd_db), .init_done(a_init_done), .busy(a_busy)
  );

  lcd_display_sequencer #(
    .NUM_LINES(4), .CHARS_PER_LINE(20),
    .CLEAR_WAIT_CYCLES(CLR_W), .REFRESH_CYCLES(REF_W), .LINE_OFFSET(8'h40)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(b_enable), .cmd_done(b_cmd_done),
    .buf_we(b_buf_we), .buf_addr(b_buf_addr), .buf_wdata(b_buf_wdata),
    .cmd_valid(b_cmd_valid), .cmd_db(b_cmd_db), .init_done(b_init_done), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_done(input bit sel, input logic v);
    if (sel) b_cmd_done = v;
    else     a_cmd_done = v;
  endtask

  task automatic drive_wr(input bit sel, input logic we, input logic [6:0] addr,
                          input logic [7:0] data);
    if (sel) begin
      b_buf_we = we; b_buf_addr = addr; b_buf_wdata = data;
    end else begin
      a_buf_we = we; a_buf_addr = addr[4:0]; a_buf_wdata = data;
    end
  endtask

  task automatic write_buf(input bit sel, input logic [6:0] addr, input logic [7:0] data);
    drive_wr(sel, 1'b1, addr, data);
    step();
    drive_wr(sel, 1'b0, '0, '0);
  endtask

  // Transmitter model: cmd_done three cycles after cmd_valid, optional write alongside
  task automatic answer(input bit sel, input bit wr, input logic [6:0] addr,
                        input logic [7:0] data);
    step(); step(); step();
    set_done(sel, 1'b1);
    if (wr) drive_wr(sel, 1'b1, addr, data);
    step();
    set_done(sel, 1'b0);
    drive_wr(sel, 1'b0, '0, '0);
  endtask

  task automatic get_cmd(input bit sel, output logic [9:0] db, output bit got);
    got = 1'b0;
    db = '0;
    last_wait = 0;
    while (!got && last_wait < 300) begin
      if (sel ? b_cmd_valid : a_cmd_valid) begin
        got = 1'b1;
        db = sel ? b_cmd_db : a_cmd_db;
      end else begin
        step();
        last_wait++;
      end
    end
  endtask

  task automatic expect_next(input bit sel, input string tag);
    logic [9:0] exp, db;
    bit got;
    exp = '0;
    check({tag, "_queued"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    get_cmd(sel, db, got);
    check({tag, "_valid"}, 32'(got), 1);
    if (got) begin
      check(tag, 32'(db), 32'(exp));
      if (db[9:8] == 2'b10) chars_seen++;
    end
  endtask

  task automatic do_cmd(input bit sel, input string tag);
    expect_next(sel, tag);
    answer(sel, 1'b0, '0, '0);
  endtask

  task automatic run_n(input bit sel, input int n, input string tag);
    for (int i = 0; i < n; i++) do_cmd(sel, $sformatf("%s_%0d", tag, i));
  endtask

  task automatic push_init();
    exp_q.push_back(10'h038);
    exp_q.push_back(10'h006);
    exp_q.push_back(10'h00C);
    exp_q.push_back(10'h001);
  endtask

  // Expected words for one refresh pass, built from the bench's buffer copy
  task automatic push_pass(input bit sel);
    int nl, nc;
    logic [7:0] b;
    nl = sel ? 4 : 2;
    nc = sel ? 20 : 16;
    for (int l = 0; l < nl; l++) begin
      b = 8'((l % 2 == 1) ? 8'h40 : 8'h00) + 8'((l / 2) * nc);
      exp_q.push_back({3'b001, b[6:0]});
      for (int c = 0; c < nc; c++)
        exp_q.push_back({2'b10, sel ? model_b[l * nc + c] : model_a[l * nc + c]});
    end
  endtask

  initial begin
    reset = 1'b1;
    a_enable = 0; a_cmd_done = 0; a_buf_we = 0; a_buf_addr = '0; a_buf_wdata = '0;
    b_enable = 0; b_cmd_done = 0; b_buf_we = 0; b_buf_addr = '0; b_buf_wdata = '0;
    for (int i = 0; i < 32; i++) model_a[i] = 8'h20;
    for (int i = 0; i < 80; i++) model_b[i] = 8'h20;
    step(); step();
    check("reset_cmd_valid", a_cmd_valid, 0);
    check("reset_cmd_db", a_cmd_db, 0);
    check("reset_init_done", a_init_done, 0);
    check("reset_busy", a_busy, 0);
    reset = 1'b0;
    step();

    // Preload 2x16 buffer with 'A'.. while idle
    for (int i = 0; i < 32; i++) begin
      model_a[i] = 8'(8'h41 + i);
      write_buf(1'b0, 7'(i), model_a[i]);
    end
    check("a_idle_busy", a_busy, 0);
    check("a_idle_no_cmd", a_cmd_valid, 0);

    // Init sequence, with a cmd_done coincident with cmd_valid on ENTRY_MODE
    push_init();
    a_enable = 1'b1;
    step();
    a_enable = 1'b0;
    do_cmd(1'b0, "a_func_set");
    expect_next(1'b0, "a_entry_mode");
    a_cmd_done = 1'b1;
    step();
    a_cmd_done = 1'b0;
    check("a_done_with_valid_ignored", a_cmd_valid, 0);
    check("a_cmd_db_held", a_cmd_db, 10'h006);
    answer(1'b0, 1'b0, '0, '0);
    do_cmd(1'b0, "a_disp_on");
    expect_next(1'b0, "a_clear");
    answer(1'b0, 1'b0, '0, '0);
    check("a_init_done_in_wait", a_init_done, 0);
    check("a_busy_in_wait", a_busy, 0);
    // cmd_done during WAIT_CLEAR must not shorten the wait
    a_cmd_done = 1'b1;
    repeat (3) step();
    a_cmd_done = 1'b0;
    push_pass(1'b0);
    expect_next(1'b0, "a_p1_addr0");
    check("a_clear_wait_cycles", last_wait + 3, CLR_W);
    check("a_init_done_set", a_init_done, 1);
    check("a_busy_in_pass", a_busy, 1);
    answer(1'b0, 1'b0, '0, '0);
    run_n(1'b0, 33, "a_p1");
    check("a_busy_in_refresh_wait", a_busy, 0);

`ifdef LCD_SEQ_DIRTY_REFRESH_EN
    begin
      int seen;
      seen = 0;
      repeat (3 * REF_W + 5) begin
        if (a_cmd_valid) seen++;
        step();
      end
      check("a_no_refresh_when_clean", seen, 0);
    end
    model_a[5] = 8'h35;
    write_buf(1'b0, 7'd5, 8'h35);
    push_pass(1'b0);
    expect_next(1'b0, "a_p2_addr0");
`else
    push_pass(1'b0);
    expect_next(1'b0, "a_p2_addr0");
    check("a_refresh_wait_cycles", last_wait, REF_W);
`endif
    answer(1'b0, 1'b0, '0, '0);
    do_cmd(1'b0, "a_p2_c0");
    do_cmd(1'b0, "a_p2_c1");
    // Write entry 3 on the very edge it is read: old char goes out this pass
    expect_next(1'b0, "a_p2_c2");
    answer(1'b0, 1'b1, 7'd3, 8'h7A);
    model_a[3] = 8'h7A;
    run_n(1'b0, 30, "a_p2");

    // Third pass shows the new char; reset partway through line 1
    push_pass(1'b0);
    run_n(1'b0, 23, "a_p3");
    expect_next(1'b0, "a_p3_mid");
    reset = 1'b1;
    a_cmd_done = 1'b1;
    #1;
    check("a_rst_cmd_valid", a_cmd_valid, 0);
    check("a_rst_cmd_db", a_cmd_db, 0);
    check("a_rst_init_done", a_init_done, 0);
    check("a_rst_busy", a_busy, 0);
    step();
    reset = 1'b0;
    a_cmd_done = 1'b0;
    step(); step();
    check("a_after_rst_idle", a_cmd_valid, 0);
    check("a_after_rst_busy", a_busy, 0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) model_a[i] = 8'h20;

    // Full restart from FUNC_SET; buffer is back to spaces
    push_init();
    a_enable = 1'b1;
    step();
    a_enable = 1'b0;
    run_n(1'b0, 3, "a_re_init");
    expect_next(1'b0, "a_re_clear");
    answer(1'b0, 1'b0, '0, '0);
    push_pass(1'b0);
    expect_next(1'b0, "a_re_addr0");
    check("a_re_clear_wait_cycles", last_wait, CLR_W);
    answer(1'b0, 1'b0, '0, '0);
    run_n(1'b0, 33, "a_re_p1");

    // 20x4 instance: four line bases and 80 chars per pass
    for (int i = 0; i < 80; i++) begin
      model_b[i] = 8'(8'h21 + i);
      write_buf(1'b1, 7'(i), model_b[i]);
    end
    write_buf(1'b1, 7'd80, 8'hEE);
    write_buf(1'b1, 7'd100, 8'hEE);
    push_init();
    b_enable = 1'b1;
    step();
    b_enable = 1'b0;
    run_n(1'b1, 3, "b_init");
    expect_next(1'b1, "b_clear");
    answer(1'b1, 1'b0, '0, '0);
    push_pass(1'b1);
    chars_seen = 0;
    expect_next(1'b1, "b_addr0");
    check("b_clear_wait_cycles", last_wait, CLR_W);
    check("b_init_done_set", b_init_done, 1);
    answer(1'b1, 1'b0, '0, '0);
    run_n(1'b1, 83, "b_p1");
    check("b_chars_per_pass", chars_seen, 80);
    check("b_busy_in_refresh_wait", b_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
